sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single SRAM port of the SRAM interface between two read clients and two write clients.
  - Read clients: rd0 = display fetch, rd1 = overlay fetch.
  - Write clients: wr0 = background capture, wr1 = foreground capture.
- Issues at most one operation per clock: one read or one write, never both. The interface's "write delayed by concurrent read" path is therefore never exercised.
- Tags every issued read and routes the returned data back to the requesting client after the fixed interface latency.
- Sits between the capture/output pipelines and the SRAM interface.

Parameters:
- READ_LATENCY, 4, clock cycles from mem_read_enable high to mem_data_out valid.
- WFIFO_DEPTH, 4, entries per write-client FIFO. Power of two, at least 2.
- STARVE_LIMIT, 8, consecutive cycles a non-empty write FIFO may go without a grant before a write slot is forced.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rd0_req  in  1  read request, display client; highest priority.
- rd0_addr  in  20  read address, display client.
- rd0_gnt  out  1  read accepted this cycle.
- rd0_valid  out  1  rd_data holds the display client's data this cycle.
- rd1_req  in  1  read request, overlay client.
- rd1_addr  in  20  read address, overlay client.
- rd1_gnt  out  1  read accepted this cycle.
- rd1_valid  out  1  rd_data holds the overlay client's data this cycle.
- rd_data  out  18  shared read-return data.
- wr0_valid / wr0_ready  in / out  1 / 1  write push handshake, background client.
- wr0_addr / wr0_data  in  20 / 18  write address and data, background client.
- wr1_valid / wr1_ready  in / out  1 / 1  write push handshake, foreground client.
- wr1_addr / wr1_data  in  20 / 18  write address and data, foreground client.
- mem_read_enable  out  1  to the interface's read_enable.
- mem_r_addr  out  20  to the interface's r_addr.
- mem_data_out  in  18  from the interface's data_out.
- mem_write_enable  out  1  to the interface's write_enable.
- mem_w_addr  out  20  to the interface's w_addr.
- mem_data_in  out  18  to the interface's data_in.

Behaviour:
- Reset: one clock, clk. Reset rst_n is asynchronous, active-low.
  - While rst_n = 0, every output is 0 except wr0_ready and wr1_ready.
  - wr0_ready and wr1_ready are also 0 during reset and rise on the first clk edge after release.
  - Reset clears FIFOs, tag pipeline, starvation counters and round-robin pointer (pointer = wr0).
  - Reads in flight when reset is asserted are dropped; no rdX_valid is produced for them.
- Write FIFOs:
  - wrX_ready = FIFO not full.
  - A push occurs when valid && ready on posedge.
  - Pointers wrap modulo WFIFO_DEPTH; an occupancy counter distinguishes full from empty.
  - A push and a pop in the same cycle leave occupancy unchanged.
  - A push into an empty FIFO becomes eligible for grant the following cycle.
- Grant decision: one per cycle, registered. mem_* outputs are registered, so the issue appears the cycle after the request is sampled. Priority order:
  1. Forced write: a FIFO's starvation counter has reached STARVE_LIMIT. If both have, the round-robin pointer chooses.
  2. rd0_req.
  3. rd1_req.
  4. Writes: round-robin between non-empty FIFOs; the pointer advances past the granted client.
- rdX_gnt is combinational in the sampling cycle. A client holding rdX_req high gets back-to-back grants; there is no bubble between reads.
- Starvation counter, per FIFO:
  - Increments each cycle the FIFO is non-empty and not granted.
  - Clears on grant or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Write issue: mem_write_enable = 1 for one cycle with the FIFO head's addr/data. The head is popped in the same cycle.
- Read issue: mem_read_enable = 1, mem_r_addr = the granted address.
- Idle cycles: mem_read_enable = mem_write_enable = 0; addr/data hold their previous values.
- Tag pipeline:
  - READ_LATENCY-deep shift register of {valid, client id}, loaded on issue.
  - At the tail, the matching rdX_valid pulses for one cycle and rd_data = mem_data_out.
  - Up to READ_LATENCY reads may be in flight; the pipeline never stalls.
  - Returns stay in issue order.
- Never: mem_read_enable and mem_write_enable both 1 in the same cycle; rd0_valid and rd1_valid both 1 in the same cycle.

Optional Feature:
- Macro: SRAM_ARB_STATS_EN.
- Defined: adds the following outputs.
  - stat_rd_count (32): count of issued reads.
  - stat_wr_count (32): count of issued writes.
  - stat_forced_count (16): count of forced write grants.
  - stat_clear (in, 1): synchronous clear of all counters.
  - Counters wrap on overflow and reset to 0 under rst_n.
- Undefined: none of these ports or counters exist; arbitration behaviour is identical in both builds.

Test Plan:
- Reset release with all inputs idle -> all mem_* outputs 0; wr0_ready/wr1_ready = 1 one cycle after release; no rdX_valid ever.
- rd0_req held for 10 cycles, addrs 0x00010..0x00019, mem_data_out echoing a function of the address -> 10 consecutive issues; rd0_valid pulses exactly READ_LATENCY cycles after each issue with the matching data; rd1_valid stays 0.
- rd0 and rd1 alternating single requests -> rd_data routed to the correct client in issue order; the valids never overlap.
- Push 4 entries into wr0 (addrs 0x100..0x103) with no reads pending -> 4 writes issued in FIFO order; wr0_ready low while the FIFO is full.
- rd0_req held continuously while wr1 holds 1 entry (addr 0xABCDE, data 0x3FFFF) -> write issued once the counter reaches STARVE_LIMIT = 8 (cycle 9 after the entry becomes eligible); the rd0 request that cycle gets no grant and is granted the next cycle.
- Both write FIFOs full, no reads, rst_n pulsed low mid-burst -> outputs zero immediately (asynchronously); FIFOs empty after release; no stale write issued.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
// Bundles the client-side and SRAM-side signals of the SRAM arbiter.
//   slave  : the arbiter's view (takes client requests and memory read data,
//            drives grants, read returns, write-ready and SRAM commands).
//   master : the opposite view (clients plus the SRAM interface model).
// Signal groups:
//   rd0_* / rd1_*  read request, address, grant and return-valid per client
//   rd_data        shared read-return data
//   wr0_* / wr1_*  valid/ready push of address+data into the write FIFOs
//   mem_*          single SRAM port (read enable/address, write enable/address/
//                  data, returned read data)
// -----------------------------------------------------------------------------
interface sram_arbiter_if;
   logic        rd0_req;
   logic [19:0] rd0_addr;
   logic        rd0_gnt;
   logic        rd0_valid;
   logic        rd1_req;
   logic [19:0] rd1_addr;
   logic        rd1_gnt;
   logic        rd1_valid;
   logic [17:0] rd_data;
   logic        wr0_valid;
   logic        wr0_ready;
   logic [19:0] wr0_addr;
   logic [17:0] wr0_data;
   logic        wr1_valid;
   logic        wr1_ready;
   logic [19:0] wr1_addr;
   logic [17:0] wr1_data;
   logic        mem_read_enable;
   logic [19:0] mem_r_addr;
   logic [17:0] mem_data_out;
   logic        mem_write_enable;
   logic [19:0] mem_w_addr;
   logic [17:0] mem_data_in;

   modport slave (
      input  rd0_req, rd0_addr, rd1_req, rd1_addr,
      input  wr0_valid, wr0_addr, wr0_data, wr1_valid, wr1_addr, wr1_data,
      input  mem_data_out,
      output rd0_gnt, rd0_valid, rd1_gnt, rd1_valid, rd_data,
      output wr0_ready, wr1_ready,
      output mem_read_enable, mem_r_addr, mem_write_enable, mem_w_addr, mem_data_in
   );

   modport master (
      output rd0_req, rd0_addr, rd1_req, rd1_addr,
      output wr0_valid, wr0_addr, wr0_data, wr1_valid, wr1_addr, wr1_data,
      output mem_data_out,
      input  rd0_gnt, rd0_valid, rd1_gnt, rd1_valid, rd_data,
      input  wr0_ready, wr1_ready,
      input  mem_read_enable, mem_r_addr, mem_write_enable, mem_w_addr, mem_data_in
   );
endinterface

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Shares one SRAM port between two read clients (rd0 display, rd1 overlay) and
// two write clients (wr0 background, wr1 foreground). One operation per clock.
// Ports:
//   clk    system clock, all logic on posedge
//   rst_n  asynchronous active-low reset
//   bus    sram_arbiter_if.slave: client read/write handshakes and SRAM port
// Optional build macro SRAM_ARB_STATS_EN adds:
//   stat_clear (in), stat_rd_count[31:0], stat_wr_count[31:0],
//   stat_forced_count[15:0] -- wrapping issue counters, cleared by stat_clear.
// Grant priority: starved write FIFO > rd0 > rd1 > round-robin writes.
// -----------------------------------------------------------------------------
module sram_arbiter #(
   parameter int READ_LATENCY = 4,
   parameter int WFIFO_DEPTH  = 4,
   parameter int STARVE_LIMIT = 8
) (
   input logic           clk,
   input logic           rst_n,
   sram_arbiter_if.slave bus
`ifdef SRAM_ARB_STATS_EN
   ,
   input  logic          stat_clear,
   output logic [31:0]   stat_rd_count,
   output logic [31:0]   stat_wr_count,
   output logic [15:0]   stat_forced_count
`endif
);
   localparam int PW = $clog2(WFIFO_DEPTH);
   localparam int CW = $clog2(WFIFO_DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   // en_q is 0 during reset and for the first cycle after release; it gates
   // write-ready and all grants so nothing is accepted before the first edge.
   logic        en_q, en_d;
   logic        rr_q, rr_d;                  // 0: wr0 has write priority
   logic [1:0]  rd_gnt, wr_gnt;
   logic        forced;
   logic [1:0]  wr_valid_in;
   logic [19:0] wr_addr_in [2];
   logic [17:0] wr_data_in [2];
   logic [1:0]  fifo_full, fifo_nempty, starved, wr_push;
   logic [37:0] fifo_head [2];              // {addr, data}

   logic        mem_re_q, mem_re_d, mem_we_q, mem_we_d;
   logic        rd_id_q, rd_id_d;
   logic [19:0] mem_r_addr_q, mem_r_addr_d, mem_w_addr_q, mem_w_addr_d;
   logic [17:0] mem_w_data_q, mem_w_data_d;
   logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d, tag_id_q, tag_id_d;

   assign wr_valid_in   = {bus.wr1_valid, bus.wr0_valid};
   assign wr_addr_in[0] = bus.wr0_addr;
   assign wr_addr_in[1] = bus.wr1_addr;
   assign wr_data_in[0] = bus.wr0_data;
   assign wr_data_in[1] = bus.wr1_data;

   // Per-client write FIFO and starvation counter.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_wfifo
         logic [37:0]   mem_q [WFIFO_DEPTH];
         logic [37:0]   mem_d [WFIFO_DEPTH];
         logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
         logic [CW-1:0] cnt_q, cnt_d;
         logic [SW-1:0] starve_q, starve_d;

         assign fifo_full[gi]   = (cnt_q == CW'(WFIFO_DEPTH));
         assign fifo_nempty[gi] = (cnt_q != '0);
         assign wr_push[gi]     = wr_valid_in[gi] & en_q & ~fifo_full[gi];
         assign fifo_head[gi]   = mem_q[rp_q];
         assign starved[gi]     = (starve_q == SW'(STARVE_LIMIT));

         always_comb begin
            mem_d    = mem_q;
            wp_d     = wp_q;
            rp_d     = rp_q;
            cnt_d    = cnt_q;
            starve_d = starve_q;
            if (wr_push[gi]) begin
               mem_d[wp_q] = {wr_addr_in[gi], wr_data_in[gi]};
               wp_d        = wp_q + 1'b1;     // power-of-two depth: wraps naturally
            end
            if (wr_gnt[gi]) rp_d = rp_q + 1'b1;
            case ({wr_push[gi], wr_gnt[gi]})
               2'b10:   cnt_d = cnt_q + 1'b1;
               2'b01:   cnt_d = cnt_q - 1'b1;
               default: cnt_d = cnt_q;
            endcase
            if (!fifo_nempty[gi] || wr_gnt[gi]) starve_d = '0;
            else if (!starved[gi])             starve_d = starve_q + 1'b1;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < WFIFO_DEPTH; i++) mem_q[i] <= '0;
               wp_q     <= '0;
               rp_q     <= '0;
               cnt_q    <= '0;
               starve_q <= '0;
            end else begin
               mem_q    <= mem_d;
               wp_q     <= wp_d;
               rp_q     <= rp_d;
               cnt_q    <= cnt_d;
               starve_q <= starve_d;
            end
         end
      end
   endgenerate

   // Pick one of two candidates; on a tie the round-robin pointer decides.
   function automatic logic [1:0] rr_pick(input logic [1:0] cand, input logic ptr);
      logic [1:0] r;
      if (cand == 2'b11) r = ptr ? 2'b10 : 2'b01;
      else               r = cand;
      return r;
   endfunction

   always_comb begin : arbitrate
      rd_gnt = 2'b00;
      wr_gnt = 2'b00;
      forced = 1'b0;
      if (en_q) begin
         if (starved != 2'b00) begin
            forced = 1'b1;
            wr_gnt = rr_pick(starved, rr_q);
         end else if (bus.rd0_req) begin
            rd_gnt = 2'b01;
         end else if (bus.rd1_req) begin
            rd_gnt = 2'b10;
         end else begin
            wr_gnt = rr_pick(fifo_nempty, rr_q);
         end
      end
   end

   always_comb begin : next_state
      en_d         = 1'b1;
      rr_d         = rr_q;
      mem_re_d     = |rd_gnt;
      mem_we_d     = |wr_gnt;
      mem_r_addr_d = mem_r_addr_q;
      rd_id_d      = rd_id_q;
      mem_w_addr_d = mem_w_addr_q;
      mem_w_data_d = mem_w_data_q;
      if (rd_gnt[0]) begin
         mem_r_addr_d = bus.rd0_addr;
         rd_id_d      = 1'b0;
      end else if (rd_gnt[1]) begin
         mem_r_addr_d = bus.rd1_addr;
         rd_id_d      = 1'b1;
      end
      if (wr_gnt != 2'b00) begin
         {mem_w_addr_d, mem_w_data_d} = wr_gnt[1] ? fifo_head[1] : fifo_head[0];
         rr_d = wr_gnt[0];                   // move priority past the winner
      end
      // Tag enters alongside the cycle mem_read_enable is high, so the tail
      // lines up with mem_data_out READ_LATENCY cycles later.
      tag_vld_d[0] = mem_re_q;
      tag_id_d[0]  = rd_id_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_id_d[i]  = tag_id_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q         <= 1'b0;
         rr_q         <= 1'b0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_r_addr_q <= '0;
         rd_id_q      <= 1'b0;
         mem_w_addr_q <= '0;
         mem_w_data_q <= '0;
         tag_vld_q    <= '0;
         tag_id_q     <= '0;
      end else begin
         en_q         <= en_d;
         rr_q         <= rr_d;
         mem_re_q     <= mem_re_d;
         mem_we_q     <= mem_we_d;
         mem_r_addr_q <= mem_r_addr_d;
         rd_id_q      <= rd_id_d;
         mem_w_addr_q <= mem_w_addr_d;
         mem_w_data_q <= mem_w_data_d;
         tag_vld_q    <= tag_vld_d;
         tag_id_q     <= tag_id_d;
      end
   end

   assign bus.rd0_gnt          = rd_gnt[0];
   assign bus.rd1_gnt          = rd_gnt[1];
   assign bus.wr0_ready        = en_q & ~fifo_full[0];
   assign bus.wr1_ready        = en_q & ~fifo_full[1];
   assign bus.rd0_valid        = tag_vld_q[READ_LATENCY-1] & ~tag_id_q[READ_LATENCY-1];
   assign bus.rd1_valid        = tag_vld_q[READ_LATENCY-1] &  tag_id_q[READ_LATENCY-1];
   assign bus.rd_data          = tag_vld_q[READ_LATENCY-1] ? bus.mem_data_out : '0;
   assign bus.mem_read_enable  = mem_re_q;
   assign bus.mem_r_addr       = mem_r_addr_q;
   assign bus.mem_write_enable = mem_we_q;
   assign bus.mem_w_addr       = mem_w_addr_q;
   assign bus.mem_data_in      = mem_w_data_q;

`ifdef SRAM_ARB_STATS_EN
   logic [31:0] stat_rd_q, stat_rd_d, stat_wr_q, stat_wr_d;
   logic [15:0] stat_forced_q, stat_forced_d;

   always_comb begin
      stat_rd_d     = stat_rd_q + {31'd0, |rd_gnt};
      stat_wr_d     = stat_wr_q + {31'd0, |wr_gnt};
      stat_forced_d = stat_forced_q + {15'd0, forced};
      if (stat_clear) begin
         stat_rd_d     = '0;
         stat_wr_d     = '0;
         stat_forced_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_rd_q     <= '0;
         stat_wr_q     <= '0;
         stat_forced_q <= '0;
      end else begin
         stat_rd_q     <= stat_rd_d;
         stat_wr_q     <= stat_wr_d;
         stat_forced_q <= stat_forced_d;
      end
   end

   assign stat_rd_count     = stat_rd_q;
   assign stat_wr_count     = stat_wr_q;
   assign stat_forced_count = stat_forced_q;
`endif
endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Drives sram_arbiter through directed scenarios and a randomized phase, and
// compares every cycle against a queue-based reference model of the arbiter
// rules. The SRAM is modelled as a fixed-latency read pipe returning a
// function of the address. One line is printed per issued memory transaction.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;
   localparam int L = 4;
   localparam int D = 4;
   localparam int S = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sram_arbiter_if bus ();

`ifdef SRAM_ARB_STATS_EN
   logic        stat_clear = 1'b0;
   logic [31:0] stat_rd_count, stat_wr_count;
   logic [15:0] stat_forced_count;
`endif

   sram_arbiter #(.READ_LATENCY(L), .WFIFO_DEPTH(D), .STARVE_LIMIT(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef SRAM_ARB_STATS_EN
      ,
      .stat_clear        (stat_clear),
      .stat_rd_count     (stat_rd_count),
      .stat_wr_count     (stat_wr_count),
      .stat_forced_count (stat_forced_count)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   task automatic check_value(input string tag, input logic [37:0] got, input logic [37:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [17:0] mem_fn(input logic [19:0] a);
      return a[17:0] ^ 18'h15A5A ^ {16'h0, a[19:18]};
   endfunction

   // SRAM model: data for a read seen on the port appears L cycles later.
   logic        hist_re   [L+1];
   logic [19:0] hist_addr [L+1];
   initial begin
      for (int i = 0; i <= L; i++) begin
         hist_re[i]   = 1'b0;
         hist_addr[i] = '0;
      end
      bus.mem_data_out = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = L; i > 0; i--) begin
            hist_re[i]   = hist_re[i-1];
            hist_addr[i] = hist_addr[i-1];
         end
         hist_re[0]   = bus.mem_read_enable;
         hist_addr[0] = bus.mem_r_addr;
         bus.mem_data_out = hist_re[L] ? mem_fn(hist_addr[L]) : 18'($urandom);
      end
   end

   // ---------------- reference model ----------------
   typedef struct {
      int          cyc;
      int          cl;
      logic [17:0] data;
   } ret_t;

   bit          alive;
   logic [37:0] wq0[$];
   logic [37:0] wq1[$];
   int          st[2];
   int          rr;
   logic        exp_re, exp_we;
   logic [19:0] exp_raddr, exp_waddr;
   logic [17:0] exp_wdata;
   ret_t        ret_q[$];

   task automatic model_clear();
      wq0.delete();
      wq1.delete();
      ret_q.delete();
      st[0] = 0; st[1] = 0; rr = 0; alive = 1'b0;
      exp_re = 1'b0; exp_we = 1'b0;
      exp_raddr = '0; exp_waddr = '0; exp_wdata = '0;
   endtask

   task automatic idle_inputs();
      bus.rd0_req = 1'b0; bus.rd0_addr = '0;
      bus.rd1_req = 1'b0; bus.rd1_addr = '0;
      bus.wr0_valid = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
      bus.wr1_valid = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_value({tag, ".rd0_gnt"},   38'(bus.rd0_gnt), 38'd0);
      check_value({tag, ".rd1_gnt"},   38'(bus.rd1_gnt), 38'd0);
      check_value({tag, ".rd0_valid"}, 38'(bus.rd0_valid), 38'd0);
      check_value({tag, ".rd1_valid"}, 38'(bus.rd1_valid), 38'd0);
      check_value({tag, ".rd_data"},   38'(bus.rd_data), 38'd0);
      check_value({tag, ".wr0_ready"}, 38'(bus.wr0_ready), 38'd0);
      check_value({tag, ".wr1_ready"}, 38'(bus.wr1_ready), 38'd0);
      check_value({tag, ".mem_re"},    38'(bus.mem_read_enable), 38'd0);
      check_value({tag, ".mem_r_addr"}, 38'(bus.mem_r_addr), 38'd0);
      check_value({tag, ".mem_we"},    38'(bus.mem_write_enable), 38'd0);
      check_value({tag, ".mem_w_addr"}, 38'(bus.mem_w_addr), 38'd0);
      check_value({tag, ".mem_data_in"}, 38'(bus.mem_data_in), 38'd0);
   endtask

   // One clock: check this cycle's outputs against the model, then advance it.
   task automatic tick();
      int          sz[2];
      bit          ne[2], rdy[2], stv[2];
      int          rd_win, wr_win;
      bit          ev0, ev1;
      logic [37:0] ent;
      @(negedge clk);
      sz[0] = wq0.size();
      sz[1] = wq1.size();
      for (int i = 0; i < 2; i++) begin
         ne[i]  = sz[i] > 0;
         rdy[i] = alive && (sz[i] < D);
         stv[i] = st[i] >= S;
      end
      rd_win = -1;
      wr_win = -1;
      if (alive) begin
         if (stv[0] || stv[1])  wr_win = (stv[0] && stv[1]) ? rr : (stv[0] ? 0 : 1);
         else if (bus.rd0_req) rd_win = 0;
         else if (bus.rd1_req) rd_win = 1;
         else if (ne[0] || ne[1]) wr_win = (ne[0] && ne[1]) ? rr : (ne[0] ? 0 : 1);
      end
      ev0 = (ret_q.size() > 0) && (ret_q[0].cyc == cyc) && (ret_q[0].cl == 0);
      ev1 = (ret_q.size() > 0) && (ret_q[0].cyc == cyc) && (ret_q[0].cl == 1);

      check_value("rd0_gnt",   38'(bus.rd0_gnt),   38'(rd_win == 0));
      check_value("rd1_gnt",   38'(bus.rd1_gnt),   38'(rd_win == 1));
      check_value("wr0_ready", 38'(bus.wr0_ready), 38'(rdy[0]));
      check_value("wr1_ready", 38'(bus.wr1_ready), 38'(rdy[1]));
      check_value("rd0_valid", 38'(bus.rd0_valid), 38'(ev0));
      check_value("rd1_valid", 38'(bus.rd1_valid), 38'(ev1));
      if (ev0 || ev1) check_value("rd_data", 38'(bus.rd_data), 38'(ret_q[0].data));
      check_value("mem_re",      38'(bus.mem_read_enable),  38'(exp_re));
      check_value("mem_r_addr",  38'(bus.mem_r_addr),       38'(exp_raddr));
      check_value("mem_we",      38'(bus.mem_write_enable), 38'(exp_we));
      check_value("mem_w_addr",  38'(bus.mem_w_addr),       38'(exp_waddr));
      check_value("mem_data_in", 38'(bus.mem_data_in),      38'(exp_wdata));

      if (ev0 || ev1) void'(ret_q.pop_front());
      ent = '0;
      if (wr_win == 0) ent = wq0.pop_front();
      if (wr_win == 1) ent = wq1.pop_front();
      if (rdy[0] && bus.wr0_valid) wq0.push_back({bus.wr0_addr, bus.wr0_data});
      if (rdy[1] && bus.wr1_valid) wq1.push_back({bus.wr1_addr, bus.wr1_data});

      exp_re = (rd_win >= 0);
      if (rd_win >= 0) begin
         exp_raddr = (rd_win == 0) ? bus.rd0_addr : bus.rd1_addr;
         ret_q.push_back('{cyc: cyc + 1 + L, cl: rd_win, data: mem_fn(exp_raddr)});
         $display("cyc %0d: RD%0d issue addr=0x%05h", cyc, rd_win, exp_raddr);
      end
      exp_we = (wr_win >= 0);
      if (wr_win >= 0) begin
         exp_waddr = ent[37:18];
         exp_wdata = ent[17:0];
         $display("cyc %0d: WR%0d issue addr=0x%05h data=0x%05h%s", cyc, wr_win,
                  exp_waddr, exp_wdata, (stv[0] || stv[1]) ? " forced" : "");
      end
      for (int i = 0; i < 2; i++) begin
         if (!ne[i] || wr_win == i) st[i] = 0;
         else if (st[i] < S)        st[i] = st[i] + 1;
      end
      if (wr_win >= 0) rr = 1 - wr_win;
      alive = 1'b1;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   // Assert reset mid-cycle, check outputs drop at once, release after an edge.
   task automatic pulse_reset(input string tag);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs(tag);
      @(posedge clk);
      @(posedge clk);
      #1;
      idle_inputs();
      model_clear();
      rst_n = 1'b1;
   endtask

   initial begin
      int first_we;
      idle_inputs();
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst_n = 1'b1;

      // Idle after release: readys rise after one edge, nothing issued.
      repeat (5) tick();

      // rd0 held for 10 cycles, consecutive addresses.
      for (int i = 0; i < 10; i++) begin
         bus.rd0_req  = 1'b1;
         bus.rd0_addr = 20'h00010 + 20'(i);
         tick();
      end
      idle_inputs();
      repeat (L + 3) tick();

      // rd0 / rd1 alternating single requests.
      for (int i = 0; i < 8; i++) begin
         idle_inputs();
         if (i % 2 == 0) begin bus.rd0_req = 1'b1; bus.rd0_addr = 20'h00200 + 20'(i); end
         else            begin bus.rd1_req = 1'b1; bus.rd1_addr = 20'h00300 + 20'(i); end
         tick();
      end
      idle_inputs();
      repeat (L + 3) tick();

      // Fill wr0 while rd1 holds the port, then one extra push against full.
      for (int i = 0; i < 5; i++) begin
         bus.rd1_req   = (i < 4);
         bus.rd1_addr  = 20'h00400 + 20'(i);
         bus.wr0_valid = 1'b1;
         bus.wr0_addr  = 20'h00100 + 20'(i);
         bus.wr0_data  = 18'h01000 + 18'(i);
         tick();
      end
      idle_inputs();
      repeat (8) tick();

      // Starvation: rd0 held while wr1 holds one entry.
      first_we = -1;
      bus.wr1_valid = 1'b1;
      bus.wr1_addr  = 20'hABCDE;
      bus.wr1_data  = 18'h3FFFF;
      for (int k = 0; k < 16; k++) begin
         bus.rd0_req  = 1'b1;
         bus.rd0_addr = 20'h00500 + 20'(k);
         tick();
         bus.wr1_valid = 1'b0;
         if (bus.mem_write_enable && first_we < 0) first_we = k;
      end
      check_value("starve_issue_tick", 38'(first_we), 38'(9));
      idle_inputs();
      repeat (L + 3) tick();

      // Both FIFOs pushed continuously with no reads, reset mid-burst.
      for (int i = 0; i < 10; i++) begin
         bus.wr0_valid = 1'b1; bus.wr0_addr = 20'h00600 + 20'(i); bus.wr0_data = 18'(i);
         bus.wr1_valid = 1'b1; bus.wr1_addr = 20'h00700 + 20'(i); bus.wr1_data = 18'(i + 100);
         tick();
      end
      pulse_reset("midburst");
      repeat (8) tick();

      // Randomized traffic with one reset in the middle.
      for (int k = 0; k < 500; k++) begin
         bus.rd0_req   = ($urandom % 4) == 0;
         bus.rd0_addr  = 20'($urandom);
         bus.rd1_req   = ($urandom % 3) == 0;
         bus.rd1_addr  = 20'($urandom);
         bus.wr0_valid = ($urandom % 2) == 0;
         bus.wr0_addr  = 20'($urandom);
         bus.wr0_data  = 18'($urandom);
         bus.wr1_valid = ($urandom % 3) == 0;
         bus.wr1_addr  = 20'($urandom);
         bus.wr1_data  = 18'($urandom);
         if (k == 250) pulse_reset("random");
         tick();
      end
      idle_inputs();
      repeat (L + 12) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
